hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NREG, 32: architectural GPR count.
- AW, $clog2(NREG): register index width.
- TW, 2: T_new/T_use width.
- MULT_LAT, 5: mult/multu busy cycles.
- DIV_LAT, 10: div/divu busy cycles.
- CNT_W, 32: stall statistics counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- issue_valid, in, 1: D-stage instruction advances into E this cycle.
- issue_wr_reg, in, AW: destination GPR of the issued instruction; 0 means none.
- issue_t_new, in, TW: cycles until the issued result is forwardable, measured at E.
- issue_mtc0_epc, in, 1: issued instruction is mtc0 to CP0 reg 14.
- md_start, in, 1: issued instruction starts the MDU.
- md_is_div, in, 1: qualifies md_start; 1 = div, 0 = mult.
- d_rs, in, AW: D-stage rs index.
- d_rt, in, AW: D-stage rt index.
- t_use_rs, in, TW: D-stage rs T_use.
- t_use_rt, in, TW: D-stage rt T_use.
- d_md_use, in, 1: D-stage instruction touches the MDU (mult/div/mf/mt).
- d_eret, in, 1: D-stage instruction is eret.
- flush, in, 1: exception/eret flush of E/M.
- stall, out, 1: freeze PC and D, bubble E.
- md_busy, out, 1: MDU countdown nonzero.
- stall_cnt, out, CNT_W: cycles with stall=1.

Function
REQ-003 The block SHALL keep one TW-bit countdown ttl[r] per register r = 1..NREG-1; r = 0 is hard-wired to zero.
REQ-004 Each cycle, every nonzero ttl SHALL decrement by 1 and saturate at 0.
REQ-005 The issue qualifier acc SHALL equal issue_valid & ~stall; when stall=1 every issue_* and md_start input SHALL be ignored.
REQ-006 When acc=1 and issue_wr_reg != 0, ttl[issue_wr_reg] SHALL load issue_t_new, taking priority over that entry's decrement.
REQ-007 The rs hazard SHALL be d_rs != 0 && ttl[d_rs] > t_use_rs; the rt hazard SHALL be the same with d_rt and t_use_rt; both SHALL be combinational from current state.
REQ-008 The MDU counter SHALL load DIV_LAT when acc & md_start & md_is_div, and MULT_LAT when acc & md_start & ~md_is_div; otherwise it SHALL decrement to 0.
REQ-009 md_busy SHALL equal (MDU counter != 0); the MDU hazard SHALL equal d_md_use & md_busy.
REQ-010 The EPC counter SHALL load 2 when acc & issue_mtc0_epc, so it covers the E and M residency; otherwise it SHALL decrement to 0.
REQ-011 The eret hazard SHALL equal d_eret & (EPC counter != 0).
REQ-012 stall SHALL be the OR of the rs, rt, MDU and eret hazards.
REQ-013 flush SHALL clear all ttl entries and the EPC counter on the next edge, with priority over acc loads; the MDU counter SHALL be unaffected because the MDU operation has already committed.
REQ-014 stall_cnt SHALL increment on each edge where stall=1 and saturate at all-ones.

Reset
REQ-015 reset_n=0 SHALL asynchronously clear all ttl entries, the MDU counter, the EPC counter and stall_cnt; stall and md_busy SHALL therefore read 0 during reset.

Structure
REQ-016 Package hazard_pkg SHALL hold the TW default, MULT_LAT/DIV_LAT defaults, the EPC index (14) and the T_new/T_use encoding constants.
REQ-017 The MDU and EPC countdowns SHALL be instances of one sub-module, hz_countdown (parametric width, load value, load enable, clear).

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Issue wr_reg=8, t_new=2; next cycle d_rs=8, t_use_rs=0 -> stall=1 for 2 cycles, then 0.
- Same issue with t_use_rs=1 -> stall=1 for exactly 1 cycle.
- Issue wr_reg=0, t_new=2; d_rs=0 -> stall never asserts.
- md_start mult, then d_md_use=1 -> stall=1 for 5 cycles; repeat with div -> 10 cycles; md_busy tracks the counter.
- issue_mtc0_epc, then d_eret=1 -> stall=1 for 2 cycles; flush in the first stall cycle -> stall=0 from the next cycle.
- CNT_W=4 with a held hazard for 20 cycles -> stall_cnt=15; reset_n pulse mid-countdown -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared defaults and encodings for the hazard scoreboard
package hazard_pkg;

  localparam int TW_DEF       = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int EPC_IDX      = 14;
  // mtc0 EPC sits in E then M before eret may read it
  localparam int EPC_HOLD     = 2;

  // T_new / T_use: cycles counted from E until a value is forwardable / needed
  localparam logic [1:0] T_E = 2'd0;
  localparam logic [1:0] T_M = 2'd1;
  localparam logic [1:0] T_W = 2'd2;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/hz_countdown.sv
// rtl/hz_countdown.sv - loadable saturating down-counter with clear priority
module hz_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clear,
  output logic         o_nz
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_nz = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - T_new/T_use register scoreboard with MDU and EPC interlocks
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int TW       = TW_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_wr_reg,
  input  logic [TW-1:0]    issue_t_new,
  input  logic             issue_mtc0_epc,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic [AW-1:0]    d_rs,
  input  logic [AW-1:0]    d_rt,
  input  logic [TW-1:0]    t_use_rs,
  input  logic [TW-1:0]    t_use_rt,
  input  logic             d_md_use,
  input  logic             d_eret,
  input  logic             flush,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MW = cnt_width(MULT_LAT, DIV_LAT);

  logic [TW-1:0]    r_ttl [NREG];
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_acc;
  logic             w_haz_rs;
  logic             w_haz_rt;
  logic             w_haz_md;
  logic             w_haz_eret;
  logic             w_epc_nz;
  logic [MW-1:0]    w_md_load_val;

  // stall feeds back into acceptance: a frozen D-stage issues a bubble
  assign w_acc      = issue_valid & ~stall;
  assign w_haz_rs   = (d_rs != '0) && (r_ttl[d_rs] > t_use_rs);
  assign w_haz_rt   = (d_rt != '0) && (r_ttl[d_rt] > t_use_rt);
  assign w_haz_md   = d_md_use & md_busy;
  assign w_haz_eret = d_eret & w_epc_nz;
  assign stall      = w_haz_rs | w_haz_rt | w_haz_md | w_haz_eret;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_ttl[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0 || flush) begin
          r_ttl[r] <= '0;
        end else if (w_acc && issue_wr_reg == AW'(r)) begin
          r_ttl[r] <= issue_t_new;
        end else if (r_ttl[r] != '0) begin
          r_ttl[r] <= r_ttl[r] - TW'(1);
        end
      end
    end
  end

  assign w_md_load_val = md_is_div ? MW'(DIV_LAT) : MW'(MULT_LAT);

  // MDU keeps counting through a flush: the operation is already committed
  hz_countdown #(.W(MW)) u_md_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_acc & md_start),
    .i_load_val (w_md_load_val),
    .i_clear    (1'b0),
    .o_nz       (md_busy)
  );

  hz_countdown #(.W(2)) u_epc_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_acc & issue_mtc0_epc),
    .i_load_val (2'(EPC_HOLD)),
    .i_clear    (flush),
    .o_nz       (w_epc_nz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (stall && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench with a ready-time reference model
module tb_hazard_scoreboard;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int TW      = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             issue_valid;
  logic [AW-1:0]    issue_wr_reg;
  logic [TW-1:0]    issue_t_new;
  logic             issue_mtc0_epc;
  logic             md_start;
  logic             md_is_div;
  logic [AW-1:0]    d_rs;
  logic [AW-1:0]    d_rt;
  logic [TW-1:0]    t_use_rs;
  logic [TW-1:0]    t_use_rt;
  logic             d_md_use;
  logic             d_eret;
  logic             flush;
  logic             stall;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .TW(TW), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_wr_reg   (issue_wr_reg),
    .issue_t_new    (issue_t_new),
    .issue_mtc0_epc (issue_mtc0_epc),
    .md_start       (md_start),
    .md_is_div      (md_is_div),
    .d_rs           (d_rs),
    .d_rt           (d_rt),
    .t_use_rs       (t_use_rs),
    .t_use_rt       (t_use_rt),
    .d_md_use       (d_md_use),
    .d_eret         (d_eret),
    .flush          (flush),
    .stall          (stall),
    .md_busy        (md_busy),
    .stall_cnt      (stall_cnt)
  );

  typedef struct {
    logic             s;
    logic             b;
    logic [CNT_W-1:0] c;
    int               cy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: absolute cycle at which each producer stops blocking its consumer
  int unsigned ready [NREG];
  int unsigned md_end;
  int unsigned epc_end;
  int unsigned cyc;
  int          m_cnt;

  function automatic int ttl_of(input int r);
    if (r == 0 || ready[r] <= cyc) return 0;
    return int'(ready[r] - cyc);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    md_end  = 0;
    epc_end = 0;
    m_cnt   = 0;
  endtask

  task automatic check(input string name, input int act, input int exp, input int cy);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cy, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall", int'(stall), int'(e.s), e.cy);
      check("md_busy", int'(md_busy), int'(e.b), e.cy);
      check("stall_cnt", int'(stall_cnt), int'(e.c), e.cy);
    end
  end

  task automatic tick();
    logic es, eb;
    logic [CNT_W-1:0] ec;
    if (!reset_n) begin
      model_clear();
      es = 1'b0;
      eb = 1'b0;
      ec = '0;
    end else begin
      es = (d_rs != 0 && ttl_of(int'(d_rs)) > int'(t_use_rs)) ||
           (d_rt != 0 && ttl_of(int'(d_rt)) > int'(t_use_rt)) ||
           (d_md_use && md_end > cyc) ||
           (d_eret && epc_end > cyc);
      eb = (md_end > cyc);
      ec = CNT_W'(m_cnt);
      if (es) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (issue_valid && !es) begin
        if (md_start) md_end = cyc + 1 + (md_is_div ? 10 : 5);
        if (!flush) begin
          if (issue_wr_reg != 0) ready[issue_wr_reg] = cyc + 1 + issue_t_new;
          if (issue_mtc0_epc) epc_end = cyc + 1 + 2;
        end
      end
      if (flush) begin
        for (int r = 0; r < NREG; r++) ready[r] = 0;
        epc_end = 0;
      end
    end
    exp_q.push_back('{es, eb, ec, int'(cyc)});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_wr_reg = '0; issue_t_new = '0; issue_mtc0_epc = 0;
    md_start = 0; md_is_div = 0; d_rs = '0; d_rt = '0; t_use_rs = '0; t_use_rt = '0;
    d_md_use = 0; d_eret = 0; flush = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue_reg(input int r, input int tn);
    idle_inputs();
    issue_valid = 1; issue_wr_reg = AW'(r); issue_t_new = TW'(tn);
    tick();
    idle_inputs();
  endtask

  task automatic rand_inputs();
    issue_valid    = 1'($urandom_range(0, 1));
    issue_wr_reg   = AW'($urandom_range(0, 7));
    issue_t_new    = TW'($urandom_range(0, 3));
    issue_mtc0_epc = ($urandom_range(0, 9) == 0);
    md_start       = ($urandom_range(0, 11) == 0);
    md_is_div      = 1'($urandom_range(0, 1));
    d_rs           = AW'($urandom_range(0, 7));
    d_rt           = AW'($urandom_range(0, 7));
    t_use_rs       = TW'($urandom_range(0, 3));
    t_use_rt       = TW'($urandom_range(0, 3));
    d_md_use       = ($urandom_range(0, 3) == 0);
    d_eret         = ($urandom_range(0, 5) == 0);
    flush          = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    cyc = 0;
    model_clear();
    @(posedge clk);
    #1;
    tick();
    reset_n = 1;
    tick();

    issue_reg(8, 2);
    d_rs = AW'(8); t_use_rs = TW'(0);
    ticks(4);

    issue_reg(8, 2);
    d_rs = AW'(8); t_use_rs = TW'(1);
    ticks(3);

    issue_reg(0, 2);
    ticks(3);

    idle_inputs();
    issue_valid = 1; md_start = 1; md_is_div = 0;
    tick();
    idle_inputs(); d_md_use = 1;
    ticks(7);
    idle_inputs();
    issue_valid = 1; md_start = 1; md_is_div = 1;
    tick();
    idle_inputs(); d_md_use = 1;
    ticks(12);

    idle_inputs();
    issue_valid = 1; issue_mtc0_epc = 1;
    tick();
    idle_inputs(); d_eret = 1;
    ticks(3);
    idle_inputs();
    issue_valid = 1; issue_mtc0_epc = 1;
    tick();
    idle_inputs(); d_eret = 1; flush = 1;
    tick();
    flush = 0;
    ticks(2);

    // Saturate the 4-bit counter with back-to-back divides held against d_md_use
    reset_n = 0; idle_inputs();
    tick();
    reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      issue_valid = 1; md_start = 1; md_is_div = 1; d_md_use = 1;
      ticks(11);
    end
    idle_inputs();
    issue_valid = 1; md_start = 1; md_is_div = 1;
    tick();
    idle_inputs(); d_md_use = 1;
    ticks(3);
    reset_n = 0;
    tick();
    reset_n = 1;
    ticks(2);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset_n = (i == 150 || i == 300) ? 1'b0 : 1'b1;
      tick();
    end
    reset_n = 1;
    idle_inputs();
    ticks(2);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
